// File: rtl/clk_div_mon_pkg.sv
// Shared definitions for the divided-clock monitor: FSM state encoding and default widths.
package clk_div_mon_pkg;

    localparam int STATE_W       = 2;
    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FAULT  = 2'd3
    } mon_state_t;

endpackage

// File: rtl/clk_div_mon_edge.sv
// Capture stage for div_in: optional two-flop synchroniser, div_q/div_q_d and rise detect.
// Build option: CLK_DIV_MON_SYNC_IN_EN inserts the synchroniser for asynchronous sources.
module clk_div_mon_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_div,
    output logic o_div_q,
    output logic o_rise
);

    logic w_div_src;
    logic r_div_q;
    logic r_div_q_d;

`ifdef CLK_DIV_MON_SYNC_IN_EN
    logic [1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], i_div};
        end
    end

    assign w_div_src = r_sync[1];
`else
    assign w_div_src = i_div;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div_q   <= 1'b0;
            r_div_q_d <= 1'b0;
        end else begin
            r_div_q   <= w_div_src;
            r_div_q_d <= r_div_q;
        end
    end

    assign o_div_q = r_div_q;
    assign o_rise  = r_div_q & ~r_div_q_d;

endmodule

// File: rtl/clk_div_monitor.sv
// Period/duty checker for a divided clock sampled in the clk domain, with lock and fault reporting.
// Build option: CLK_DIV_MON_SYNC_IN_EN (see clk_div_mon_edge) adds two cycles of input latency.
module clk_div_monitor
    import clk_div_mon_pkg::*;
#(
    parameter int DIV_RATIO   = 9,
    parameter int HIGH_CYCLES = 4,
    parameter int LOCK_COUNT  = 4,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    output logic             locked,
    output logic             period_err,
    output logic             duty_err,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]  C_MAX     = '1;
    localparam logic [CNT_W-1:0]  C_DIV     = CNT_W'(DIV_RATIO);
    localparam logic [CNT_W-1:0]  C_HIGH    = CNT_W'(HIGH_CYCLES);
    localparam logic [CNT_W-1:0]  C_TO_LAST = CNT_W'(2 * DIV_RATIO - 1);
    localparam logic [GOOD_W-1:0] C_LOCK    = GOOD_W'(LOCK_COUNT);
    localparam logic [GOOD_W-1:0] C_LOCK_M1 = GOOD_W'(LOCK_COUNT - 1);

    logic w_div_q;
    logic w_rise;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hacc;
    logic [CNT_W-1:0] w_meas_period;
    logic             w_period_bad;
    logic             w_duty_bad;
    logic             w_meas_good;
    logic             w_measure;
    logic             w_timeout;

    mon_state_t        r_state;
    mon_state_t        w_state_next;
    logic [GOOD_W-1:0] r_good;
    logic [GOOD_W-1:0] w_good_next;
    logic              w_perr_next;
    logic              w_derr_next;

    clk_div_mon_edge u_edge (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_div   (div_in),
        .o_div_q (w_div_q),
        .o_rise  (w_rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_hacc <= '0;
        end else begin
            if (w_rise) begin
                r_cnt <= '0;
            end else if (r_cnt != C_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_rise) begin
                r_hacc <= CNT_W'(1);
            end else if (w_div_q && (r_hacc != C_MAX)) begin
                r_hacc <= r_hacc + CNT_W'(1);
            end
        end
    end

    assign w_meas_period = (r_cnt == C_MAX) ? C_MAX : (r_cnt + CNT_W'(1));
    assign w_period_bad  = (w_meas_period != C_DIV);
    assign w_duty_bad    = (r_hacc != C_HIGH);
    assign w_meas_good   = ~w_period_bad & ~w_duty_bad;
    assign w_measure     = w_rise && (r_state != ST_IDLE);
    // cnt saturates past the threshold, so this compare can only fire once per rise
    assign w_timeout     = (r_state != ST_IDLE) && !w_rise && (r_cnt == C_TO_LAST);

    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good;
        w_perr_next  = 1'b0;
        w_derr_next  = 1'b0;

        if (w_measure) begin
            w_perr_next = w_period_bad;
            w_derr_next = w_duty_bad;
        end else if (w_timeout) begin
            w_perr_next = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_next = ST_ACQ;
                    w_good_next  = '0;
                end
            end
            ST_ACQ: begin
                if (w_rise) begin
                    if (!w_meas_good) begin
                        w_good_next = '0;
                    end else if (r_good == C_LOCK_M1) begin
                        w_good_next  = C_LOCK;
                        w_state_next = ST_LOCKED;
                    end else begin
                        w_good_next = r_good + GOOD_W'(1);
                    end
                end else if (w_timeout) begin
                    w_good_next = '0;
                end
            end
            ST_LOCKED: begin
                if ((w_rise && !w_meas_good) || w_timeout) begin
                    w_state_next = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (w_rise) begin
                    w_state_next = ST_ACQ;
                    w_good_next  = '0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_good_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_good     <= '0;
            period_err <= 1'b0;
            duty_err   <= 1'b0;
            period_cnt <= '0;
            high_cnt   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_good     <= w_good_next;
            period_err <= w_perr_next;
            duty_err   <= w_derr_next;
            if (w_measure) begin
                period_cnt <= w_meas_period;
                high_cnt   <= r_hacc;
            end
        end
    end

    assign locked = (r_state == ST_LOCKED);

endmodule
